// File: rtl/bird_pattern_shifter.sv
// bird_pattern_shifter: multi-channel bird flight/visibility pattern shifter.
// A programmable divider produces a one-cycle tick. On every tick each channel
// shifts its pattern one place according to the shared mode. A free-running
// 16-bit Galois LFSR can be used in place of external data when loading.
module bird_pattern_shifter #(
    parameter int          WIDTH     = 20,
    parameter int          CHANNELS  = 4,
    parameter int          DIV_WIDTH = 26,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] period,
    input  logic [1:0]           mode,
    input  logic                 load_en,
    input  logic [CHANNELS-1:0]  load_sel,
    input  logic                 load_src,
    input  logic [WIDTH-1:0]     load_data,
    output logic                 tick,
    output logic [CHANNELS-1:0]  s,
    output logic [CHANNELS-1:0]  empty,
    output logic [15:0]          rand_out
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int          REPS      = (WIDTH / 16) + 1;

    localparam logic [1:0] MODE_RIGHT  = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    logic [DIV_WIDTH-1:0] count_r;
    logic                 tick_r;
    logic [15:0]          lfsr_r;
    logic [15:0]          lfsr_next_s;
    logic [WIDTH-1:0]     pattern_s;
    logic [WIDTH-1:0]     shreg_r      [CHANNELS];
    logic [WIDTH-1:0]     shreg_next_s [CHANNELS];

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] q);
        logic [15:0] nxt;
        nxt = {1'b0, q[15:1]};
        if (q[0]) begin
            nxt = nxt ^ LFSR_MASK;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    // LFSR state replicated LSB-aligned and truncated to the channel width.
    function automatic logic [WIDTH-1:0] lfsr_replicate(input logic [15:0] q);
        logic [16*REPS-1:0] wide;
        wide = {REPS{q}};
        return wide[WIDTH-1:0];
    endfunction

    // Rotate a channel-wide vector left by n places.
    function automatic logic [WIDTH-1:0] rotate_left(input logic [WIDTH-1:0] v, input int n);
        int k;
        k = n % WIDTH;
        if (k == 0) begin
            return v;
        end else begin
            return (v << k) | (v >> (WIDTH - k));
        end
    endfunction

    // LFSR successor and the shared pattern vector derived from the current state.
    always_comb begin
        lfsr_next_s = lfsr_advance(lfsr_r);
        pattern_s   = lfsr_replicate(lfsr_r);
    end

    // Next value of every channel: a load wins, otherwise shift on tick.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            shreg_next_s[ch] = shreg_r[ch];
            if (load_en && load_sel[ch]) begin
                if (load_src) begin
                    shreg_next_s[ch] = rotate_left(pattern_s, ch);
                end else begin
                    shreg_next_s[ch] = load_data;
                end
            end else if (tick_r) begin
                case (mode)
                    MODE_RIGHT:  shreg_next_s[ch] = {1'b0, shreg_r[ch][WIDTH-1:1]};
                    MODE_LEFT:   shreg_next_s[ch] = {shreg_r[ch][WIDTH-2:0], 1'b0};
                    MODE_ROTATE: shreg_next_s[ch] = {shreg_r[ch][0], shreg_r[ch][WIDTH-1:1]};
                    MODE_HOLD:   shreg_next_s[ch] = shreg_r[ch];
                    default:     shreg_next_s[ch] = shreg_r[ch];
                endcase
            end else begin
                shreg_next_s[ch] = shreg_r[ch];
            end
        end
    end

    // Rate divider: reload and pulse tick when the count reaches zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {DIV_WIDTH{1'b0}};
            tick_r  <= 1'b0;
        end else if (enable) begin
            if (count_r == {DIV_WIDTH{1'b0}}) begin
                count_r <= period;
                tick_r  <= 1'b1;
            end else begin
                count_r <= count_r - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
                tick_r  <= 1'b0;
            end
        end else begin
            count_r <= count_r;
            tick_r  <= 1'b0;
        end
    end

    // Free-running LFSR, advancing every cycle regardless of enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_r <= SEED_INIT;
        end else begin
            lfsr_r <= lfsr_next_s;
        end
    end

    // Channel shift registers.
    always_ff @(posedge clock) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (reset) begin
                shreg_r[ch] <= {WIDTH{1'b0}};
            end else begin
                shreg_r[ch] <= shreg_next_s[ch];
            end
        end
    end

    // Serial bit follows the end of the register that leaves first in the current mode.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (mode == MODE_LEFT) begin
                s[ch] = shreg_r[ch][WIDTH-1];
            end else begin
                s[ch] = shreg_r[ch][0];
            end
            empty[ch] = (shreg_r[ch] == {WIDTH{1'b0}});
        end
    end

    assign tick     = tick_r;
    assign rand_out = lfsr_r;

endmodule

// File: tb/tb_bird_pattern_shifter.sv
// Self-checking bench for bird_pattern_shifter: directed scenarios followed by
// randomized traffic, all compared against an arithmetic reference model.
module tb_bird_pattern_shifter;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [25:0] period;
    logic [1:0]  mode;
    logic        load_en;
    logic [3:0]  load_sel;
    logic        load_src;
    logic [19:0] load_data;
    logic        tick;
    logic [3:0]  s;
    logic [3:0]  empty;
    logic [15:0] rand_out;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int unsigned m_reg [4];
    longint      m_cnt;
    bit          m_tick;
    int unsigned m_lfsr;

    bird_pattern_shifter #(
        .WIDTH(20), .CHANNELS(4), .DIV_WIDTH(26), .LFSR_SEED(16'hACE1)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .period(period),
        .mode(mode), .load_en(load_en), .load_sel(load_sel), .load_src(load_src),
        .load_data(load_data), .tick(tick), .s(s), .empty(empty), .rand_out(rand_out)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // LFSR word spread over 20 bits (low nibble repeats at the top), rotated left ch times.
    function automatic int unsigned lfsr_fill(input int unsigned q, input int ch);
        int unsigned v;
        v = q + (q % 16) * 65536;
        for (int k = 0; k < ch; k++) begin
            v = ((v * 2) % 1048576) + (v / 524288);
        end
        return v;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        if (reset) begin
            m_cnt  = 0;
            m_tick = 0;
            m_lfsr = 32'hACE1;
            for (int ch = 0; ch < 4; ch++) m_reg[ch] = 0;
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                if (load_en && load_sel[ch]) begin
                    m_reg[ch] = load_src ? lfsr_fill(m_lfsr, ch) : 32'(load_data);
                end else if (m_tick) begin
                    case (mode)
                        2'd0: m_reg[ch] = m_reg[ch] / 2;
                        2'd1: m_reg[ch] = (m_reg[ch] * 2) % 1048576;
                        2'd2: m_reg[ch] = m_reg[ch] / 2 + (m_reg[ch] % 2) * 524288;
                        default: m_reg[ch] = m_reg[ch];
                    endcase
                end
            end
            m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 32'hB400) : (m_lfsr / 2);
            if (enable) begin
                if (m_cnt == 0) begin
                    m_cnt  = longint'(period);
                    m_tick = 1;
                end else begin
                    m_cnt  = m_cnt - 1;
                    m_tick = 0;
                end
            end else begin
                m_tick = 0;
            end
        end
    endtask

    // Compare every DUT output with the model.
    task automatic compare_all();
        logic [3:0] exp_s;
        logic [3:0] exp_e;
        exp_s = 4'd0;
        exp_e = 4'd0;
        for (int ch = 0; ch < 4; ch++) begin
            int unsigned b;
            b = (mode == 2'b01) ? (m_reg[ch] / 524288) : (m_reg[ch] % 2);
            exp_s = exp_s | (4'(b) << ch);
            exp_e = exp_e | (4'(m_reg[ch] == 0) << ch);
        end
        check_value("tick", 32'(tick), 32'(m_tick));
        check_value("s", 32'(s), 32'(exp_s));
        check_value("empty", 32'(empty), 32'(exp_e));
        check_value("rand_out", 32'(rand_out), m_lfsr);
    endtask

    // Inputs are set just after a falling edge; the model steps, then outputs are checked on the next falling edge.
    task automatic run_cycle();
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic quiet_inputs();
        enable = 1'b0; period = 26'd0; mode = 2'b11; load_en = 1'b0;
        load_sel = 4'd0; load_src = 1'b0; load_data = 20'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
    endtask

    logic [4:0] t2_s0;
    logic [4:0] t2_e0;

    initial begin
        t2_s0 = 5'b00101;   // index 0 first: 1,0,1,0,0
        t2_e0 = 5'b11000;   // empty from the third shift on
        reset = 1'b1;
        quiet_inputs();

        // Test 1: reset values, divider with period 3, enable drop and resume.
        period = 26'd3;
        run_cycle();
        check_value("t1_rst_rand", 32'(rand_out), 32'hACE1);
        check_value("t1_rst_empty", 32'(empty), 32'hF);
        check_value("t1_rst_tick", 32'(tick), 32'h0);
        reset = 1'b0;
        enable = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            run_cycle();
            check_value("t1_tick", 32'(tick), 32'(c % 4 == 1));
            if (c == 1) check_value("t1_rand_next", 32'(rand_out), 32'hE270);
        end
        enable = 1'b0;
        for (int c = 0; c < 6; c++) begin
            run_cycle();
            check_value("t1_hold_tick", 32'(tick), 32'h0);
        end
        enable = 1'b1;
        repeat (10) run_cycle();

        // Test 2: right shift of 20'h00005 at full rate.
        do_reset();
        enable = 1'b1; period = 26'd0; mode = 2'b00;
        load_en = 1'b1; load_sel = 4'b0001; load_data = 20'h00005;
        run_cycle();
        load_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_value("t2_s0", 32'(s[0]), 32'(t2_s0[c]));
            check_value("t2_empty0", 32'(empty[0]), 32'(t2_e0[c]));
            check_value("t2_others", 32'(empty[3:1]), 32'h7);
            run_cycle();
        end

        // Test 3: rotate never empties, hold freezes.
        do_reset();
        enable = 1'b1; period = 26'd0; mode = 2'b10;
        load_en = 1'b1; load_sel = 4'b0010; load_data = 20'h80001;
        run_cycle();
        load_en = 1'b0;
        for (int c = 0; c < 41; c++) begin
            run_cycle();
            check_value("t3_empty1", 32'(empty[1]), 32'h0);
        end
        mode = 2'b11;
        repeat (6) run_cycle();

        // Test 4: LFSR loads right after reset, then shift the patterns out.
        do_reset();
        load_en = 1'b1; load_sel = 4'b0011; load_src = 1'b1;
        run_cycle();
        check_value("t4_loaded", 32'(empty), 32'hC);
        load_en = 1'b0; load_src = 1'b0;
        mode = 2'b00; enable = 1'b1; period = 26'd0;
        repeat (22) run_cycle();

        // Test 5: load coinciding with a tick edge.
        do_reset();
        enable = 1'b1; period = 26'd2; mode = 2'b01;
        load_en = 1'b1; load_sel = 4'b1111; load_data = 20'h0F0F1;
        run_cycle();
        load_en = 1'b0;
        repeat (2) run_cycle();
        mode = 2'b00;
        run_cycle();
        check_value("t5_tick_edge", 32'(tick), 32'h1);
        load_en = 1'b1; load_sel = 4'b0001; load_data = 20'hABCDE;
        run_cycle();
        load_en = 1'b0;
        repeat (4) run_cycle();

        // Test 6: reset in the middle of activity.
        period = 26'd5;
        load_en = 1'b1; load_sel = 4'b1110; load_src = 1'b1;
        run_cycle();
        load_en = 1'b0;
        repeat (2) run_cycle();
        reset = 1'b1; load_en = 1'b1; load_sel = 4'b1111;
        run_cycle();
        check_value("t6_empty", 32'(empty), 32'hF);
        check_value("t6_tick", 32'(tick), 32'h0);
        check_value("t6_rand", 32'(rand_out), 32'hACE1);
        reset = 1'b0; load_en = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            enable    = ($urandom_range(0, 7) != 0);
            period    = 26'($urandom_range(0, 5));
            mode      = 2'($urandom_range(0, 3));
            load_en   = ($urandom_range(0, 5) == 0);
            load_sel  = 4'($urandom_range(0, 15));
            load_src  = 1'($urandom_range(0, 1));
            load_data = 20'($urandom);
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
